ether_rx_framer: RTL and testbench

- Parametrised receive framer for the RMII (2-bit) or MII (4-bit) PHY data path.
- Validates preamble length and SFD, then strips them.
- Forwards payload symbols as a valid/data stream and also assembles bytes (LSB-first).
- Reports per-frame start/end, byte count and framing errors to the downstream CRC/packet logic.

---
 rtl/ether_rx_framer_if.sv | 25 ++
 rtl/ether_rx_framer.sv | 118 +++++++++++
 tb/tb_ether_rx_framer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ether_rx_framer_if.sv
// ether_rx_framer_if: PHY receive symbols in, framed payload stream and frame status out
interface ether_rx_framer_if #(
  parameter int DW = 2,
  parameter int LEN_W = 11
);
  logic [DW-1:0] rxd;
  logic crsdv;
  logic axiov;
  logic [DW-1:0] axiod;
  logic sof;
  logic eof;
  logic byte_valid;
  logic [7:0] byte_data;
  logic [LEN_W-1:0] frame_len;
  logic pre_err;
  logic odd_err;
  modport master (
    output rxd, crsdv,
    input axiov, axiod, sof, eof, byte_valid, byte_data, frame_len, pre_err, odd_err
  );
  modport slave (
    input rxd, crsdv,
    output axiov, axiod, sof, eof, byte_valid, byte_data, frame_len, pre_err, odd_err
  );
endinterface

// File: rtl/ether_rx_framer.sv
// ether_rx_framer: RMII/MII receive framer checking preamble/SFD, streaming payload and assembling bytes
module ether_rx_framer #(
  parameter int DW = 2,
  parameter int PRE_MIN = 28,
  parameter int PRE_MAX = 31,
  parameter int LEN_W = 11
) (
  input logic clk,
  input logic rst,
  ether_rx_framer_if.slave bus
);
  localparam int SPB = 8 / DW;
  localparam int KW = $clog2(SPB);
  localparam int PW = $clog2(PRE_MAX + 1);
  localparam logic [DW-1:0] PRE_SYM = DW'((DW == 4) ? 5 : 1);
  localparam logic [DW-1:0] SFD_SYM = DW'((DW == 4) ? 13 : 3);
  localparam logic [PW-1:0] PMIN = PW'(PRE_MIN);
  localparam logic [PW-1:0] PMAX = PW'(PRE_MAX);
  localparam logic [KW-1:0] KLAST = KW'(SPB - 1);
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DRAIN} state_t;
  state_t r_state;
  logic [PW-1:0] r_pcnt;
  logic [KW-1:0] r_k;
  logic [7:0] r_asm, w_asm;
  logic [LEN_W-1:0] r_bcnt;
  logic r_first;
  logic r_axiov, r_sof, r_eof, r_byte_valid, r_pre_err, r_odd_err;
  logic [DW-1:0] r_axiod;
  logic [7:0] r_byte_data;
  logic [LEN_W-1:0] r_frame_len;
  always_comb begin
    w_asm = r_asm;
    w_asm[r_k*DW +: DW] = bus.rxd;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DRAIN;
      r_pcnt <= '0;
      r_k <= '0;
      r_asm <= '0;
      r_bcnt <= '0;
      r_first <= 1'b0;
      r_axiov <= 1'b0;
      r_axiod <= '0;
      r_sof <= 1'b0;
      r_eof <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte_data <= '0;
      r_frame_len <= '0;
      r_pre_err <= 1'b0;
      r_odd_err <= 1'b0;
    end else begin
      r_axiov <= 1'b0;
      r_axiod <= '0;
      r_sof <= 1'b0;
      r_eof <= 1'b0;
      r_byte_valid <= 1'b0;
      r_pre_err <= 1'b0;
      r_odd_err <= 1'b0;
      case (r_state)
        IDLE: if (bus.crsdv && bus.rxd == PRE_SYM) begin
          r_state <= PREAMBLE;
          r_pcnt <= PW'(1);
        end
        PREAMBLE: if (!bus.crsdv) begin
          r_pre_err <= 1'b1;
          r_state <= IDLE;
        end else if (bus.rxd == PRE_SYM) begin
          if (r_pcnt == PMAX) begin
            r_pre_err <= 1'b1;
            r_state <= DRAIN;
          end else r_pcnt <= r_pcnt + 1'b1;
        end else if (bus.rxd == SFD_SYM && r_pcnt >= PMIN) begin
          r_state <= PAYLOAD;
          r_asm <= '0;
          r_bcnt <= '0;
          r_k <= '0;
          r_first <= 1'b1;
        end else begin
          r_pre_err <= 1'b1;
          r_state <= DRAIN;
        end
        PAYLOAD: if (bus.crsdv) begin
          r_axiov <= 1'b1;
          r_axiod <= bus.rxd;
          r_sof <= r_first;
          r_first <= 1'b0;
          if (r_k == KLAST) begin
            r_byte_valid <= 1'b1;
            r_byte_data <= w_asm;
            r_asm <= '0;
            r_k <= '0;
            r_bcnt <= &r_bcnt ? r_bcnt : r_bcnt + 1'b1;
          end else begin
            r_asm <= w_asm;
            r_k <= r_k + 1'b1;
          end
        end else begin
          r_eof <= 1'b1;
          r_frame_len <= r_bcnt;
          r_odd_err <= r_k != '0;
          r_k <= '0;
          r_state <= IDLE;
        end
        default: if (!bus.crsdv) r_state <= IDLE;
      endcase
    end
  end
  assign bus.axiov = r_axiov;
  assign bus.axiod = r_axiod;
  assign bus.sof = r_sof;
  assign bus.eof = r_eof;
  assign bus.byte_valid = r_byte_valid;
  assign bus.byte_data = r_byte_data;
  assign bus.frame_len = r_frame_len;
  assign bus.pre_err = r_pre_err;
  assign bus.odd_err = r_odd_err;
endmodule

// File: tb/tb_ether_rx_framer.sv
// tb_ether_rx_framer: directed scenarios on an RMII (DW=2) and an MII (DW=4) framer
module tb_ether_rx_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ether_rx_framer_if #(.DW(2), .LEN_W(11)) b2();
  ether_rx_framer_if #(.DW(4), .LEN_W(11)) b4();
  ether_rx_framer #(.DW(2), .PRE_MIN(28), .PRE_MAX(31), .LEN_W(11)) d2 (.clk(clk), .rst(rst), .bus(b2.slave));
  ether_rx_framer #(.DW(4), .PRE_MIN(14), .PRE_MAX(15), .LEN_W(11)) d4 (.clk(clk), .rst(rst), .bus(b4.slave));
  int checks = 0;
  int failures = 0;
  int n_axv, n_sof, n_eof, n_pe;

  task automatic tick();
    @(posedge clk);
    #1;
    n_axv += int'(b2.axiov);
    n_sof += int'(b2.sof);
    n_eof += int'(b2.eof);
    n_pe += int'(b2.pre_err);
  endtask

  task automatic clr();
    n_axv = 0; n_sof = 0; n_eof = 0; n_pe = 0;
  endtask

  task automatic sym2(input logic [1:0] s);
    b2.rxd = s; b2.crsdv = 1'b1; tick();
  endtask

  task automatic idle2();
    b2.rxd = 2'b00; b2.crsdv = 1'b0; tick();
  endtask

  task automatic pre2(input int n);
    repeat (n) sym2(2'b01);
  endtask

  task automatic sym4(input logic [3:0] s);
    b4.rxd = s; b4.crsdv = 1'b1; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b2.rxd = 2'b01; b2.crsdv = 1'b1;
    b4.rxd = 4'h0; b4.crsdv = 1'b0;
    tick(); tick();
    checks++; if ({b2.axiov, b2.axiod, b2.sof, b2.eof, b2.byte_valid, b2.pre_err, b2.odd_err} !== 9'd0) begin failures++; $display("FAIL reset_flags got=%b exp=0", {b2.axiov, b2.axiod, b2.sof, b2.eof, b2.byte_valid, b2.pre_err, b2.odd_err}); end
    checks++; if (b2.byte_data !== 8'h00) begin failures++; $display("FAIL reset_byte_data got=%h exp=00", b2.byte_data); end
    checks++; if (b2.frame_len !== 11'd0) begin failures++; $display("FAIL reset_frame_len got=%0d exp=0", b2.frame_len); end
    rst = 1'b0;
    clr();
    pre2(31); sym2(2'b11); sym2(2'b00);
    checks++; if (n_axv !== 0 || n_pe !== 0) begin failures++; $display("FAIL reset_drain axv=%0d pe=%0d exp=0/0", n_axv, n_pe); end
    idle2();
  endtask

  task automatic test_frame_dw2();
    logic [1:0] p [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
    clr();
    pre2(31); sym2(2'b11);
    checks++; if (b2.axiov !== 1'b0) begin failures++; $display("FAIL dw2_sfd_axiov got=%b exp=0", b2.axiov); end
    for (int i = 0; i < 8; i++) begin
      sym2(p[i]);
      checks++; if (b2.axiov !== 1'b1 || b2.axiod !== p[i]) begin failures++; $display("FAIL dw2_sym%0d got=%b/%b exp=1/%b", i, b2.axiov, b2.axiod, p[i]); end
      checks++; if (b2.sof !== (i == 0)) begin failures++; $display("FAIL dw2_sof%0d got=%b exp=%b", i, b2.sof, i == 0); end
      checks++; if (b2.byte_valid !== (i == 3 || i == 7)) begin failures++; $display("FAIL dw2_bv%0d got=%b exp=%b", i, b2.byte_valid, i == 3 || i == 7); end
    end
    checks++; if (b2.byte_data !== 8'h1B) begin failures++; $display("FAIL dw2_byte2 got=%h exp=1b", b2.byte_data); end
    idle2();
    checks++; if (b2.eof !== 1'b1 || b2.axiov !== 1'b0 || b2.axiod !== 2'b00) begin failures++; $display("FAIL dw2_eof got=%b%b%b exp=100", b2.eof, b2.axiov, b2.axiod); end
    checks++; if (b2.frame_len !== 11'd2 || b2.odd_err !== 1'b0) begin failures++; $display("FAIL dw2_len got=%0d/%b exp=2/0", b2.frame_len, b2.odd_err); end
    idle2();
    checks++; if (b2.eof !== 1'b0 || n_sof !== 1 || n_eof !== 1) begin failures++; $display("FAIL dw2_pulses eof=%b sof=%0d eofs=%0d exp=0/1/1", b2.eof, n_sof, n_eof); end
  endtask

  task automatic test_first_byte_dw2();
    clr();
    pre2(31); sym2(2'b11);
    sym2(2'b00); sym2(2'b01); sym2(2'b10); sym2(2'b11);
    checks++; if (b2.byte_valid !== 1'b1 || b2.byte_data !== 8'hE4) begin failures++; $display("FAIL dw2_byte1 got=%b/%h exp=1/e4", b2.byte_valid, b2.byte_data); end
    sym2(2'b01);
    idle2();
    checks++; if (b2.odd_err !== 1'b1 || b2.frame_len !== 11'd1 || b2.byte_valid !== 1'b0) begin failures++; $display("FAIL dw2_odd got=%b/%0d/%b exp=1/1/0", b2.odd_err, b2.frame_len, b2.byte_valid); end
  endtask

  task automatic test_short_preamble();
    clr();
    pre2(20); sym2(2'b11);
    checks++; if (b2.pre_err !== 1'b1) begin failures++; $display("FAIL short_pre_err got=%b exp=1", b2.pre_err); end
    sym2(2'b01); sym2(2'b01); sym2(2'b11); sym2(2'b10); sym2(2'b00);
    idle2();
    checks++; if (n_axv !== 0 || n_sof !== 0 || n_eof !== 0 || n_pe !== 1) begin failures++; $display("FAIL short_quiet axv=%0d sof=%0d eof=%0d pe=%0d exp=0/0/0/1", n_axv, n_sof, n_eof, n_pe); end
    checks++; if (b2.frame_len !== 11'd1) begin failures++; $display("FAIL short_len_hold got=%0d exp=1", b2.frame_len); end
  endtask

  task automatic test_bad_symbol();
    clr();
    pre2(10); sym2(2'b00);
    checks++; if (b2.pre_err !== 1'b1) begin failures++; $display("FAIL bad_pre_err got=%b exp=1", b2.pre_err); end
    pre2(30); sym2(2'b11); sym2(2'b10);
    checks++; if (n_axv !== 0 || n_pe !== 1) begin failures++; $display("FAIL bad_drain axv=%0d pe=%0d exp=0/1", n_axv, n_pe); end
    idle2();
    pre2(28); sym2(2'b11);
    repeat (4) sym2(2'b10);
    checks++; if (b2.byte_valid !== 1'b1 || b2.byte_data !== 8'hAA) begin failures++; $display("FAIL bad_recover_byte got=%b/%h exp=1/aa", b2.byte_valid, b2.byte_data); end
    idle2();
    checks++; if (b2.eof !== 1'b1 || b2.frame_len !== 11'd1 || n_sof !== 1) begin failures++; $display("FAIL bad_recover_eof got=%b/%0d/%0d exp=1/1/1", b2.eof, b2.frame_len, n_sof); end
  endtask

  task automatic test_pre_max();
    clr();
    pre2(32);
    checks++; if (b2.pre_err !== 1'b1) begin failures++; $display("FAIL premax_err got=%b exp=1", b2.pre_err); end
    sym2(2'b11); sym2(2'b00); sym2(2'b01);
    idle2();
    checks++; if (n_axv !== 0 || n_pe !== 1) begin failures++; $display("FAIL premax_quiet axv=%0d pe=%0d exp=0/1", n_axv, n_pe); end
    clr();
    pre2(5); idle2();
    checks++; if (b2.pre_err !== 1'b1 || b2.frame_len !== 11'd1) begin failures++; $display("FAIL carrier_drop got=%b/%0d exp=1/1", b2.pre_err, b2.frame_len); end
  endtask

  task automatic test_dw4();
    sym4(4'h0);
    b4.crsdv = 1'b0; tick();
    repeat (15) sym4(4'h5);
    sym4(4'hD);
    sym4(4'h3);
    checks++; if (b4.axiov !== 1'b1 || b4.axiod !== 4'h3 || b4.sof !== 1'b1) begin failures++; $display("FAIL dw4_first got=%b/%h/%b exp=1/3/1", b4.axiov, b4.axiod, b4.sof); end
    sym4(4'hA);
    checks++; if (b4.byte_valid !== 1'b1 || b4.byte_data !== 8'hA3 || b4.sof !== 1'b0) begin failures++; $display("FAIL dw4_byte got=%b/%h/%b exp=1/a3/0", b4.byte_valid, b4.byte_data, b4.sof); end
    sym4(4'h7);
    checks++; if (b4.byte_valid !== 1'b0 || b4.axiod !== 4'h7) begin failures++; $display("FAIL dw4_partial got=%b/%h exp=0/7", b4.byte_valid, b4.axiod); end
    b4.crsdv = 1'b0; b4.rxd = 4'h0; tick();
    checks++; if (b4.eof !== 1'b1 || b4.frame_len !== 11'd1 || b4.odd_err !== 1'b1 || b4.byte_valid !== 1'b0) begin failures++; $display("FAIL dw4_eof got=%b/%0d/%b/%b exp=1/1/1/0", b4.eof, b4.frame_len, b4.odd_err, b4.byte_valid); end
  endtask

  task automatic test_rst_mid_frame();
    clr();
    pre2(31); sym2(2'b11); sym2(2'b01); sym2(2'b10);
    b2.rxd = 2'b11; rst = 1'b1; tick();
    checks++; if (b2.axiov !== 1'b0 || b2.sof !== 1'b0 || b2.eof !== 1'b0 || b2.frame_len !== 11'd0) begin failures++; $display("FAIL rst_mid got=%b%b%b/%0d exp=000/0", b2.axiov, b2.sof, b2.eof, b2.frame_len); end
    rst = 1'b0;
    clr();
    sym2(2'b11); pre2(31); sym2(2'b11); sym2(2'b00); sym2(2'b00); sym2(2'b00); sym2(2'b00);
    idle2();
    checks++; if (n_axv !== 0 || n_eof !== 0 || n_pe !== 0) begin failures++; $display("FAIL rst_ignored axv=%0d eof=%0d pe=%0d exp=0/0/0", n_axv, n_eof, n_pe); end
    pre2(31); sym2(2'b11);
    sym2(2'b11); sym2(2'b00); sym2(2'b00); sym2(2'b00);
    checks++; if (b2.byte_valid !== 1'b1 || b2.byte_data !== 8'h03) begin failures++; $display("FAIL rst_next_byte got=%b/%h exp=1/03", b2.byte_valid, b2.byte_data); end
    idle2();
    checks++; if (b2.eof !== 1'b1 || b2.frame_len !== 11'd1 || n_sof !== 1) begin failures++; $display("FAIL rst_next_eof got=%b/%0d/%0d exp=1/1/1", b2.eof, b2.frame_len, n_sof); end
  endtask

  task automatic test_back_to_back();
    clr();
    pre2(28); sym2(2'b11);
    repeat (4) sym2(2'b01);
    idle2();
    checks++; if (b2.eof !== 1'b1 || b2.frame_len !== 11'd1) begin failures++; $display("FAIL b2b_eof1 got=%b/%0d exp=1/1", b2.eof, b2.frame_len); end
    pre2(29); sym2(2'b11);
    sym2(2'b01);
    checks++; if (b2.sof !== 1'b1) begin failures++; $display("FAIL b2b_sof2 got=%b exp=1", b2.sof); end
    repeat (7) sym2(2'b01);
    checks++; if (b2.byte_valid !== 1'b1 || b2.byte_data !== 8'h55) begin failures++; $display("FAIL b2b_byte got=%b/%h exp=1/55", b2.byte_valid, b2.byte_data); end
    idle2();
    checks++; if (b2.eof !== 1'b1 || b2.frame_len !== 11'd2 || b2.odd_err !== 1'b0) begin failures++; $display("FAIL b2b_eof2 got=%b/%0d/%b exp=1/2/0", b2.eof, b2.frame_len, b2.odd_err); end
    checks++; if (n_sof !== 2 || n_eof !== 2 || n_axv !== 12 || n_pe !== 0) begin failures++; $display("FAIL b2b_counts sof=%0d eof=%0d axv=%0d pe=%0d exp=2/2/12/0", n_sof, n_eof, n_axv, n_pe); end
  endtask

  initial begin
    b2.rxd = '0; b2.crsdv = 1'b0;
    b4.rxd = '0; b4.crsdv = 1'b0;
    clr();
    test_reset();
    test_frame_dw2();
    test_first_byte_dw2();
    test_short_preamble();
    test_bad_symbol();
    test_pre_max();
    test_dw4();
    test_rst_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
